// File: rtl/audio_note_sequencer.sv
// Melody player: walks a {period,duration} note ROM and streams square-wave samples to the audio FIFO.
// First sample 3 cycles after start; a full FIFO only drops samples, note timing never stalls.
module audio_note_sequencer #(
  parameter int          ADDR_W    = 5,
  parameter int          PERIOD_W  = 19,
  parameter int          DUR_W     = 8,
  parameter int          TICK_DIV  = 5000000,
  parameter logic [31:0] AMPLITUDE = 32'd10000000
) (
  input  logic                      CLOCK_50,
  input  logic                      resetn,
  input  logic                      start,
  input  logic                      stop,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [PERIOD_W+DUR_W-1:0] rom_data,
  input  logic                      audio_out_allowed,
  output logic                      write_audio_out,
  output logic [31:0]               left_channel_audio_out,
  output logic [31:0]               right_channel_audio_out,
  output logic                      busy,
  output logic                      done
);

  localparam int                PS_W          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0]   PS_MAX        = PS_W'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST     = '1;
  localparam logic [31:0]       NEG_AMPLITUDE = ~AMPLITUDE + 32'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PLAY,
    S_END
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_W-1:0]     r_addr;
  logic [PERIOD_W-1:0]   r_period;
  logic [DUR_W-1:0]      r_dur;
  logic [PERIOD_W-1:0]   r_hp_cnt;
  logic                  r_phase;
  logic [PS_W-1:0]       r_presc;
  logic [DUR_W-1:0]      r_tick;
  logic [31:0]           r_sample;

  logic [PERIOD_W-1:0]   w_rom_period;
  logic [DUR_W-1:0]      w_rom_dur;
  logic                  w_note_expired;
  logic                  w_hp_wrap;
  logic                  w_presc_wrap;
  logic                  w_phase_nxt;
  logic [PERIOD_W-1:0]   w_period_nxt;
  logic [31:0]           w_sample_nxt;

  assign w_rom_period   = rom_data[PERIOD_W+DUR_W-1:DUR_W];
  assign w_rom_dur      = rom_data[DUR_W-1:0];
  assign w_note_expired = (r_tick == r_dur);
  assign w_hp_wrap      = (r_hp_cnt == r_period);
  assign w_presc_wrap   = (r_presc == PS_MAX);

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    busy            = (r_state != S_IDLE);
    done            = 1'b0;
    write_audio_out = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_FETCH;
      S_FETCH: w_state_nxt = S_LOAD;
      S_LOAD: begin
        if ((w_rom_period == '0) && (w_rom_dur == '0)) w_state_nxt = S_END;
        else                                           w_state_nxt = S_PLAY;
      end
      S_PLAY: begin
        write_audio_out = audio_out_allowed && (r_dur != '0);
        if (w_note_expired) begin
          w_state_nxt = (r_addr == ADDR_LAST) ? S_END : S_FETCH;
        end
      end
      S_END: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (stop) w_state_nxt = S_IDLE;
  end

  // The sample register is loaded with the value for the upcoming cycle, so the
  // first PLAY cycle already presents the first half-wave level.
  always_comb begin
    w_phase_nxt  = r_phase;
    w_period_nxt = r_period;
    if (r_state == S_LOAD) begin
      w_phase_nxt  = 1'b1;
      w_period_nxt = w_rom_period;
    end else if ((r_state == S_PLAY) && w_hp_wrap) begin
      w_phase_nxt = ~r_phase;
    end
    w_sample_nxt = 32'd0;
    if ((w_state_nxt == S_PLAY) && (w_period_nxt != '0)) begin
      w_sample_nxt = w_phase_nxt ? AMPLITUDE : NEG_AMPLITUDE;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      r_addr   <= '0;
      r_period <= '0;
      r_dur    <= '0;
      r_hp_cnt <= '0;
      r_phase  <= 1'b1;
      r_presc  <= '0;
      r_tick   <= '0;
      r_sample <= 32'd0;
    end else begin
      r_sample <= w_sample_nxt;
      r_phase  <= w_phase_nxt;
      if (stop) begin
        r_addr <= '0;
      end else begin
        case (r_state)
          S_IDLE: r_addr <= '0;
          S_LOAD: begin
            r_period <= w_rom_period;
            r_dur    <= w_rom_dur;
            r_hp_cnt <= '0;
            r_presc  <= '0;
            r_tick   <= '0;
          end
          S_PLAY: begin
            r_hp_cnt <= w_hp_wrap ? '0 : r_hp_cnt + PERIOD_W'(1);
            r_presc  <= w_presc_wrap ? '0 : r_presc + PS_W'(1);
            if (w_presc_wrap) r_tick <= r_tick + DUR_W'(1);
            if (w_note_expired && (r_addr != ADDR_LAST)) r_addr <= r_addr + ADDR_W'(1);
          end
          S_END:   r_addr <= '0;
          default: r_addr <= r_addr;
        endcase
      end
    end
  end

  assign rom_addr                = r_addr;
  assign left_channel_audio_out  = r_sample;
  assign right_channel_audio_out = r_sample;

endmodule

// File: doc/audio_note_sequencer.md
# audio_note_sequencer

Plays a stored melody through the audio output path. It walks a note ROM of {period, duration} entries, generates a square-wave tone per note, and feeds the samples into the Audio_Controller output FIFO using the `audio_out_allowed`/`write_audio_out` handshake. It sits between the note ROM (MIF-initialised) and Audio_Controller, and replaces the free-running tone and rate-divider logic in the top level.

## Interface
- `ADDR_W`, 5: note ROM address width; the song holds at most 2^ADDR_W entries.
- `PERIOD_W`, 19: half-period field width, in CLOCK_50 cycles.
- `DUR_W`, 8: duration field width, in ticks.
- `TICK_DIV`, 5000000: CLOCK_50 cycles per duration tick (0.1 s).
- `AMPLITUDE`, 32'd10000000: square-wave magnitude.

- `CLOCK_50`  in  1  system clock; all logic is on the rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins playback at address 0.
- `stop`  in  1  aborts playback.
- `rom_addr`  out  ADDR_W  note ROM address.
- `rom_data`  in  PERIOD_W+DUR_W  {period[PERIOD_W+DUR_W-1:DUR_W], duration[DUR_W-1:0]}. The ROM is registered: data arrives 1 cycle after the address.
- `audio_out_allowed`  in  1  Audio_Controller output FIFO has space.
- `write_audio_out`  out  1  sample write strobe.
- `left_channel_audio_out`  out  32  sample, two's complement.
- `right_channel_audio_out`  out  32  identical to the left channel.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the song ends normally.

## Operation
- States:
  - IDLE -> FETCH on `start`.
  - FETCH drives `rom_addr` -> LOAD.
  - LOAD latches `rom_data` into the period/duration registers -> END when period==0 and duration==0, otherwise -> PLAY.
  - PLAY -> FETCH when the note has expired and `rom_addr`!=2^ADDR_W-1; `rom_addr` increments by 1 on that transition.
  - PLAY -> END when the note has expired at the last address. There is no wrap-around.
  - END asserts `done` -> IDLE.
- Note entry encoding:
  - period!=0: tone.
  - period==0, duration!=0: rest. Samples are 0 and are still written.
  - period==0, duration==0: end-of-song marker.
  - period!=0, duration==0: zero-length note. PLAY lasts exactly 1 cycle and no sample is written.
- Tone generation:
  - Half-period counter `hp_cnt` (PERIOD_W bits) resets to 0 in LOAD.
  - In PLAY: if `hp_cnt`==period, then `hp_cnt`<=0 and phase toggles; otherwise `hp_cnt`+1.
  - Each half-wave therefore lasts period+1 cycles.
  - Phase is set to 1 in LOAD.
- Sample value: rest -> 0; phase=1 -> +AMPLITUDE; phase=0 -> -AMPLITUDE (32-bit two's complement).
  - Both channel outputs are registered and updated every PLAY cycle.
  - They are held at 0 outside PLAY.
- Duration timing:
  - Tick prescaler counts 0..TICK_DIV-1 and wraps.
  - Tick counter (DUR_W bits) increments on each wrap.
  - Both counters clear in LOAD.
  - The note expires in the cycle where the tick counter equals duration.
- Handshake:
  - `write_audio_out` = (state==PLAY) & `audio_out_allowed` & (duration!=0). It is combinational from the state register and input.
  - The sample presented is the registered value in that cycle.
  - No write occurs when `audio_out_allowed`=0. The sample stream simply skips; the tone timing never stalls.
- `stop`:
  - Any state -> IDLE on the next edge.
  - Channels and `rom_addr` go to 0; `done` is not pulsed.
  - If `stop` and `start` are asserted in the same cycle, `stop` wins.
  - `start` while `busy` is ignored.
- `resetn`=0 overrides everything.

## Timing
- Reset values: `rom_addr`=0, `write_audio_out`=0, both channels=0, `busy`=0, `done`=0, state=IDLE, phase=1, all counters 0.
- `start` sampled at edge N: FETCH at N+1, LOAD at N+2, PLAY at N+3. The first `write_audio_out` can occur in cycle N+3.
- Note boundary to the next note's PLAY: 3 cycles (FETCH, LOAD, first PLAY cycle). Channels read 0 during FETCH/LOAD.
- Tone note PLAY length: duration*TICK_DIV+1 cycles.
- End marker at address k: `done` is high for exactly 1 cycle, 2 cycles after FETCH of k (the END state). `busy` falls the cycle after.
- Last-address expiry: END, `done` pulse, IDLE. `rom_addr` returns to 0 in IDLE.

## Test plan
- Use TICK_DIV=10 for all scenarios.
- ROM {period=4, dur=2}, {0,0}; `audio_out_allowed`=1; `start` pulse:
  - Samples alternate 5×+10000000 and 5×-10000000.
  - PLAY lasts 21 cycles.
  - `done` pulses once; 21 writes occur in total.
- ROM {0,3}, {0,0}:
  - 31 writes, all value 0.
  - `busy` is high from the cycle after `start` until the cycle after `done`.
- `audio_out_allowed` toggled 1/0 every cycle during a 2-tick note:
  - Writes occur only in allowed cycles (11 of 21).
  - Note length is still 21 cycles.
- `stop` asserted 7 cycles into PLAY:
  - State goes to IDLE next cycle; channels and `rom_addr` become 0.
  - No `done`; no further writes.
  - A following `start` replays from address 0.
- ADDR_W=2, all 4 entries {2,1}, no end marker:
  - 4 notes play at addresses 0,1,2,3.
  - `done` follows address 3 with no wrap.
  - A `start` pulse mid-song is ignored.
- `start` and `stop` asserted in the same cycle from IDLE: stays IDLE. `resetn` low mid-PLAY: all outputs at reset values on the next edge.
